debug_frame_collector: RTL and testbench

//  Receiving end of the debugger dump stream: reassembles the byte stream emitted per

---
 rtl/debug_frame_collector_pkg.sv | 27 ++
 rtl/debug_frame_collector_if.sv | 33 +++
 rtl/debug_frame_collector_watchdog.sv | 31 +++
 rtl/debug_frame_collector.sv | 132 +++++++++++++
 tb/tb_debug_frame_collector.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_frame_collector_pkg.sv
// Shared definitions for the debugger dump path: command codes, frame size,
// collector state encoding and the byte-count width helper.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_FAST = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;

  // 2 pad bits + 32-bit cycle count + 2526 bits of pipe state
  localparam int DBG_FRAME_BYTES = 320;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_COLLECT = ST_COLLECT_ENC,
    ST_HOLD    = ST_HOLD_ENC
  } state_t;

  // Wide enough to hold every value 0..frame_bytes inclusive
  function automatic int byte_count_width(input int frame_bytes);
    return $clog2(frame_bytes + 1);
  endfunction

endpackage

// File: rtl/debug_frame_collector_if.sv
// Byte-in / frame-out bundle of the dump collector; slave is the collector,
// master is the UART side plus the frame consumer.
interface debug_frame_collector_if
  import debug_pkg::*;
#(
  parameter int FRAME_BYTES = DBG_FRAME_BYTES
);

  localparam int CW = byte_count_width(FRAME_BYTES);

  logic [7:0]               i_rx_data;
  logic                     is_rx_done;
  logic                     is_arm;
  logic                     is_abort;
  logic [FRAME_BYTES*8-1:0] o_frame;
  logic                     os_frame_valid;
  logic                     is_frame_ready;
  logic [CW-1:0]            o_byte_count;
  logic                     os_timeout;
  logic                     os_overrun;
  logic                     os_busy;

  modport master (
    output i_rx_data, is_rx_done, is_arm, is_abort, is_frame_ready,
    input  o_frame, os_frame_valid, o_byte_count, os_timeout, os_overrun, os_busy
  );

  modport slave (
    input  i_rx_data, is_rx_done, is_arm, is_abort, is_frame_ready,
    output o_frame, os_frame_valid, o_byte_count, os_timeout, os_overrun, os_busy
  );

endinterface

// File: rtl/debug_frame_collector_watchdog.sv
// Inter-byte idle watchdog: expire is combinational, asserted on the idle clock
// where the count reaches TIMEOUT_CYCLES-1; load always wins over counting.
module debug_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] cnt_q;

  assign expire = enable && (cnt_q == LIMIT);

  // Stop at the limit so the counter never wraps while the FSM leaves COLLECT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (enable && !expire) begin
      cnt_q <= cnt_q + WW'(1);
    end
  end

endmodule

// File: rtl/debug_frame_collector.sv
// Reassembles the LSB-first dump byte stream into one frame; valid 1 cycle after
// the last byte, held until ready; bytes arriving while held are dropped and flagged.
module debug_frame_collector
  import debug_pkg::*;
#(
  parameter int FRAME_BYTES    = DBG_FRAME_BYTES,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  debug_frame_collector_if.slave  bus
);

  localparam int CW = byte_count_width(FRAME_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);

  state_t                       state_q, state_d;
  logic [CW-1:0]                count_q;
  logic [FRAME_BYTES-1:0][7:0]  frame_q;
  logic                         timeout_q;
  logic                         overrun_q;

  logic arm_go;
  logic drop_frame;
  logic wr_en;
  logic last_wr;
  logic set_timeout;
  logic set_overrun;
  logic release_frame;
  logic wd_load;
  logic wd_enable;
  logic wd_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort outranks every other event once a frame is in flight
  always_comb begin
    arm_go        = 1'b0;
    drop_frame    = 1'b0;
    wr_en         = 1'b0;
    last_wr       = 1'b0;
    set_timeout   = 1'b0;
    set_overrun   = 1'b0;
    release_frame = 1'b0;
    state_d       = state_q;

    case (state_q)
      ST_IDLE: begin
        arm_go = bus.is_arm && !bus.is_abort;
        if (arm_go) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        drop_frame  = bus.is_abort;
        wr_en       = !bus.is_abort && bus.is_rx_done;
        last_wr     = wr_en && (count_q == LAST_IDX);
        set_timeout = !bus.is_abort && wd_expire;
        if (drop_frame)       state_d = ST_IDLE;
        else if (last_wr)     state_d = ST_HOLD;
        else if (set_timeout) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        drop_frame    = bus.is_abort;
        set_overrun   = !bus.is_abort && bus.is_rx_done;
        release_frame = !bus.is_abort && bus.is_frame_ready;
        if (drop_frame || release_frame) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A timeout leaves the count untouched so the host can see how far it got
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (arm_go || drop_frame || release_frame) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (arm_go) begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (set_timeout) timeout_q <= 1'b1;
      if (set_overrun) overrun_q <= 1'b1;
    end
  end

  // Per-byte enable decoded from the count; the frame is never shifted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else begin
      for (int k = 0; k < FRAME_BYTES; k++) begin
        if (wr_en && (count_q == CW'(k))) frame_q[k] <= bus.i_rx_data;
      end
    end
  end

  assign wd_load   = arm_go || wr_en;
  assign wd_enable = (state_q == ST_COLLECT) && !bus.is_rx_done;

  debug_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  assign bus.o_frame        = frame_q;
  assign bus.os_frame_valid = (state_q == ST_HOLD);
  assign bus.o_byte_count   = count_q;
  assign bus.os_timeout     = timeout_q;
  assign bus.os_overrun     = overrun_q;
  assign bus.os_busy        = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_debug_frame_collector.sv
// Directed bench for debug_frame_collector with a queue-free byte-list model and
// per-cycle comparison, plus literal expectations at the scenario milestones.
module tb_debug_frame_collector;

  localparam int FB = 4;
  localparam int TO = 16;

  logic clk;
  logic rst;

  debug_frame_collector_if #(.FRAME_BYTES(FB)) bus ();

  debug_frame_collector #(
    .FRAME_BYTES   (FB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: what the collector should present, derived from the behaviour rules
  bit          m_collecting;
  bit          m_holding;
  int          m_count;
  int          m_idle;
  logic [31:0] m_frame;
  bit          m_to;
  bit          m_ov;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_collecting = 1'b0;
    m_holding    = 1'b0;
    m_count      = 0;
    m_idle       = 0;
    m_frame      = '0;
    m_to         = 1'b0;
    m_ov         = 1'b0;
  endtask

  task automatic model_step();
    if (m_collecting) begin
      if (bus.is_abort) begin
        m_collecting = 1'b0;
        m_count      = 0;
      end else if (bus.is_rx_done) begin
        m_frame[m_count*8 +: 8] = bus.i_rx_data;
        m_count++;
        m_idle = 0;
        if (m_count == FB) begin
          m_collecting = 1'b0;
          m_holding    = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_collecting = 1'b0;
          m_to         = 1'b1;
        end
      end
    end else if (m_holding) begin
      if (bus.is_abort) begin
        m_holding = 1'b0;
        m_count   = 0;
      end else begin
        if (bus.is_rx_done) m_ov = 1'b1;
        if (bus.is_frame_ready) begin
          m_holding = 1'b0;
          m_count   = 0;
        end
      end
    end else if (bus.is_arm && !bus.is_abort) begin
      m_collecting = 1'b1;
      m_count      = 0;
      m_idle       = 0;
      m_to         = 1'b0;
      m_ov         = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_frame",   64'(bus.o_frame),        64'(m_frame));
      chk("cyc_valid",   64'(bus.os_frame_valid), 64'(m_holding));
      chk("cyc_count",   64'(bus.o_byte_count),   64'(m_count));
      chk("cyc_timeout", 64'(bus.os_timeout),     64'(m_to));
      chk("cyc_overrun", 64'(bus.os_overrun),     64'(m_ov));
      chk("cyc_busy",    64'(bus.os_busy),        64'(m_collecting));
    end
  end

  task automatic drive(input logic rd, input logic [7:0] d, input logic arm,
                       input logic ab, input logic rdy);
    bus.is_rx_done     = rd;
    bus.i_rx_data      = d;
    bus.is_arm         = arm;
    bus.is_abort       = ab;
    bus.is_frame_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic arm();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.i_rx_data      = '0;
    bus.is_rx_done     = 1'b0;
    bus.is_arm         = 1'b0;
    bus.is_abort       = 1'b0;
    bus.is_frame_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    chk("rst_frame",   64'(bus.o_frame),        64'h0);
    chk("rst_valid",   64'(bus.os_frame_valid), 64'h0);
    chk("rst_count",   64'(bus.o_byte_count),   64'h0);
    chk("rst_flags",   64'({bus.os_timeout, bus.os_overrun, bus.os_busy}), 64'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Bytes before arming are ignored
    put(8'h99);
    chk("idle_ignore", 64'(bus.o_byte_count), 64'h0);

    // Basic frame, then a stalled consumer
    arm();
    chk("t1_busy", 64'(bus.os_busy), 64'h1);
    put(8'h11); put(8'h22); put(8'h33);
    chk("t1_novalid", 64'(bus.os_frame_valid), 64'h0);
    put(8'h44);
    chk("t1_valid", 64'(bus.os_frame_valid), 64'h1);
    chk("t1_frame", 64'(bus.o_frame),        64'h44332211);
    chk("t1_count", 64'(bus.o_byte_count),   64'h4);
    idle(10);
    chk("t1_held",  64'(bus.os_frame_valid), 64'h1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t1_drop",  64'(bus.os_frame_valid), 64'h0);
    chk("t1_clr",   64'(bus.o_byte_count),   64'h0);
    chk("t1_keep",  64'(bus.o_frame),        64'h44332211);

    // Inter-byte timeout
    arm();
    put(8'hAB); put(8'hCD);
    idle(TO - 1);
    chk("t2_pre",   64'({bus.os_timeout, bus.os_busy}), 64'h1);
    idle(1);
    chk("t2_to",    64'(bus.os_timeout),     64'h1);
    chk("t2_idle",  64'(bus.os_busy),        64'h0);
    chk("t2_count", 64'(bus.o_byte_count),   64'h2);
    chk("t2_valid", 64'(bus.os_frame_valid), 64'h0);

    // Overrun while held, then abort out of HOLD keeps the flag
    arm();
    chk("t3_toclr", 64'(bus.os_timeout), 64'h0);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    put(8'hAA);
    chk("t3_ovr",   64'(bus.os_overrun), 64'h1);
    chk("t3_frame", 64'(bus.o_frame),    64'h04030201);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_abort", 64'({bus.os_frame_valid, bus.os_overrun}), 64'h1);

    // Abort mid-frame, re-arm with a simultaneous byte, arm during COLLECT ignored
    arm();
    put(8'hE1); put(8'hE2); put(8'hE3);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t4_count", 64'(bus.o_byte_count), 64'h0);
    chk("t4_busy",  64'(bus.os_busy),      64'h0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("t4_nocap", 64'(bus.o_byte_count), 64'h0);
    put(8'h5A);
    drive(1'b1, 8'h6B, 1'b1, 1'b0, 1'b0);
    put(8'h7C); put(8'h8D);
    chk("t4_frame", 64'(bus.o_frame), 64'h8D7C6B5A);
    chk("t4_flags", 64'({bus.os_timeout, bus.os_overrun}), 64'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Arm together with abort: abort wins, stays IDLE
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("t5_armab", 64'(bus.os_busy), 64'h0);

    // Strobe exactly on the expiry cycle is stored, no timeout
    arm();
    idle(TO - 1);
    put(8'h77);
    chk("t6_win",   64'({bus.os_timeout, bus.os_busy}), 64'h1);
    chk("t6_count", 64'(bus.o_byte_count), 64'h1);
    chk("t6_frame", 64'(bus.o_frame),      64'h8D7C6B77);

    // Asynchronous reset in the middle of a frame
    put(8'h88);
    #2;
    rst    = 1'b1;
    chk_en = 1'b0;
    #1;
    chk("t7_frame", 64'(bus.o_frame),      64'h0);
    chk("t7_count", 64'(bus.o_byte_count), 64'h0);
    chk("t7_flags", 64'({bus.os_frame_valid, bus.os_timeout, bus.os_overrun, bus.os_busy}), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk_en = 1'b1;
    chk("t7_idle", 64'(bus.os_busy), 64'h0);
    put(8'h12);
    chk("t7_ign",  64'(bus.o_byte_count), 64'h0);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
